// File: rtl/tmds_channel_encoder_if.sv
// Symbol-in / character-out bundle for one TMDS lane.
interface tmds_channel_encoder_if;
  logic [1:0]        mode;
  logic [7:0]        din;
  logic [1:0]        ctrl;
  logic [3:0]        terc4;
  logic [9:0]        tmds;
  logic signed [5:0] disparity;

  modport master (
    output mode, din, ctrl, terc4,
    input  tmds, disparity
  );

  modport slave (
    input  mode, din, ctrl, terc4,
    output tmds, disparity
  );
endinterface

// File: rtl/tmds_channel_encoder.sv
// One TMDS lane encoder: symbol in, 10-bit character out, two-stage pipeline.
// Stage 1 builds the transition-minimised word; stage 2 applies DC balance
// for video or picks a fixed code for control, guard band and TERC4.
module tmds_channel_encoder #(
  parameter int CHANNEL = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  tmds_channel_encoder_if.slave bus
);

  localparam logic [1:0] MODE_CTRL  = 2'd0;
  localparam logic [1:0] MODE_VIDEO = 2'd1;
  localparam logic [1:0] MODE_GUARD = 2'd2;
  localparam logic [1:0] MODE_TERC4 = 2'd3;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;
  localparam logic [9:0] GUARD   = (CHANNEL == 1) ? 10'b0100110011 : 10'b1011001100;

  logic [1:0]        mode_q,  mode_d;
  logic [1:0]        ctrl_q,  ctrl_d;
  logic [3:0]        terc4_q, terc4_d;
  logic [8:0]        qm_q,    qm_d;
  logic [3:0]        n1_q,    n1_d;
  logic [9:0]        tmds_q,  tmds_d;
  logic signed [5:0] cnt_q,   cnt_d;

  logic [7:0]        din_m;
  logic [3:0]        n1d;
  logic              use_xnor;
  logic signed [5:0] diff;
  logic signed [5:0] q8x2;
  logic signed [5:0] nq8x2;

  // Stage 1: mask unused inputs so they cannot leak, then build q_m and its popcount.
  always_comb begin
    din_m    = (bus.mode == MODE_VIDEO) ? bus.din : 8'h00;
    n1d      = '0;
    for (int i = 0; i < 8; i++) n1d = n1d + {3'b000, din_m[i]};
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !din_m[0]);
    qm_d     = '0;
    qm_d[0]  = din_m[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ din_m[i]) : (qm_d[i-1] ^ din_m[i]);
    end
    qm_d[8]  = ~use_xnor;
    n1_d     = '0;
    for (int i = 0; i < 8; i++) n1_d = n1_d + {3'b000, qm_d[i]};
    mode_d   = bus.mode;
    ctrl_d   = (bus.mode == MODE_CTRL)  ? bus.ctrl  : 2'b00;
    terc4_d  = (bus.mode == MODE_TERC4) ? bus.terc4 : 4'h0;
  end

  // Stage 1 registers; reset leaves a control-00 symbol in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode_q  <= MODE_CTRL;
      ctrl_q  <= 2'b00;
      terc4_q <= 4'h0;
      qm_q    <= '0;
      n1_q    <= '0;
    end else begin
      mode_q  <= mode_d;
      ctrl_q  <= ctrl_d;
      terc4_q <= terc4_d;
      qm_q    <= qm_d;
      n1_q    <= n1_d;
    end
  end

  // Stage 2: DC-balanced video or table lookup; any non-video symbol zeroes the disparity.
  always_comb begin
    tmds_d = CTRL_00;
    cnt_d  = '0;
    diff   = $signed({1'b0, n1_q, 1'b0}) - 6'sd8;
    q8x2   = $signed({3'b000, qm_q[8], 2'b00}) >>> 1;
    nq8x2  = $signed({3'b000, ~qm_q[8], 2'b00}) >>> 1;
    case (mode_q)
      MODE_VIDEO: begin
        if ((cnt_q == 6'sd0) || (n1_q == 4'd4)) begin
          tmds_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
          cnt_d  = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
        end else if ((!cnt_q[5] && (n1_q > 4'd4)) || (cnt_q[5] && (n1_q < 4'd4))) begin
          tmds_d = {1'b1, qm_q[8], ~qm_q[7:0]};
          cnt_d  = cnt_q + q8x2 - diff;
        end else begin
          tmds_d = {1'b0, qm_q[8], qm_q[7:0]};
          cnt_d  = cnt_q + diff - nq8x2;
        end
      end
      MODE_CTRL: begin
        case (ctrl_q)
          2'b00:   tmds_d = CTRL_00;
          2'b01:   tmds_d = CTRL_01;
          2'b10:   tmds_d = CTRL_10;
          default: tmds_d = CTRL_11;
        endcase
      end
      MODE_GUARD: tmds_d = GUARD;
      default: begin
        case (terc4_q)
          4'h0:    tmds_d = 10'b1010011100;
          4'h1:    tmds_d = 10'b1001100011;
          4'h2:    tmds_d = 10'b1011100100;
          4'h3:    tmds_d = 10'b1011100010;
          4'h4:    tmds_d = 10'b0101110001;
          4'h5:    tmds_d = 10'b0100011110;
          4'h6:    tmds_d = 10'b0110001110;
          4'h7:    tmds_d = 10'b0100111100;
          4'h8:    tmds_d = 10'b1011001100;
          4'h9:    tmds_d = 10'b0100111001;
          4'hA:    tmds_d = 10'b0110011100;
          4'hB:    tmds_d = 10'b1011000110;
          4'hC:    tmds_d = 10'b1010001110;
          4'hD:    tmds_d = 10'b1001110001;
          4'hE:    tmds_d = 10'b0101100011;
          default: tmds_d = 10'b1011000011;
        endcase
      end
    endcase
  end

  // Stage 2 registers; async reset drives the output straight to control 00.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmds_q <= CTRL_00;
      cnt_q  <= '0;
    end else begin
      tmds_q <= tmds_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.tmds      = tmds_q;
  assign bus.disparity = cnt_q;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Bench for tmds_channel_encoder: lanes 0 and 1 driven in parallel, scoreboard checked
// two clocks after each issued symbol.
module tb_tmds_channel_encoder;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  tmds_channel_encoder_if bus0 ();
  tmds_channel_encoder_if bus1 ();

  tmds_channel_encoder #(.CHANNEL(0)) dut0 (.clk(clk), .resetn(resetn), .bus(bus0));
  tmds_channel_encoder #(.CHANNEL(1)) dut1 (.clk(clk), .resetn(resetn), .bus(bus1));

  typedef struct {
    logic [9:0] t0;
    logic [9:0] t1;
    int         d;
    bit         dec;
    logic [7:0] din;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   model_cnt = 0;
  bit   issue = 1'b0;
  bit   vld1, vld2;

  logic [9:0] terc4_tab [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };
  logic [9:0] ctrl_tab [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [7:0] d, input int cin,
                                output logic [9:0] t, output int cout);
    logic [8:0] q;
    int ones, n1, n0;
    ones = $countones(d);
    q[0] = d[0];
    if (ones > 4 || (ones == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) q[i] = q[i-1] ~^ d[i];
      q[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i];
      q[8] = 1'b1;
    end
    n1 = $countones(q[7:0]);
    n0 = 8 - n1;
    if (cin == 0 || n1 == n0) begin
      t    = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
      cout = cin + (q[8] ? (n1 - n0) : (n0 - n1));
    end else if ((cin > 0 && n1 > n0) || (cin < 0 && n0 > n1)) begin
      t    = {1'b1, q[8], ~q[7:0]};
      cout = cin + (q[8] ? 2 : 0) + (n0 - n1);
    end else begin
      t    = {1'b0, q[8], q[7:0]};
      cout = cin + (n1 - n0) - (q[8] ? 0 : 2);
    end
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] t);
    logic [7:0] b, d;
    b = t[9] ? ~t[7:0] : t[7:0];
    d[0] = b[0];
    for (int i = 1; i < 8; i++) d[i] = t[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
    return d;
  endfunction

  task automatic drive(input logic [1:0] m, input logic [7:0] d, input logic [1:0] c,
                       input logic [3:0] t4);
    bus0.mode = m; bus0.din = d; bus0.ctrl = c; bus0.terc4 = t4;
    bus1.mode = m; bus1.din = d; bus1.ctrl = c; bus1.terc4 = t4;
  endtask

  task automatic send(input logic [1:0] m, input logic [7:0] d, input logic [1:0] c,
                      input logic [3:0] t4, input logic [9:0] e0, input logic [9:0] e1,
                      input int ed, input bit dec, input string nm);
    exp_t e;
    @(negedge clk);
    drive(m, d, c, t4);
    issue = 1'b1;
    e.t0 = e0; e.t1 = e1; e.d = ed; e.dec = dec; e.din = d; e.nm = nm;
    sb.push_back(e);
    if (m != 2'd1) model_cnt = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(2'd0, 8'h00, 2'b00, 4'h0);
      issue = 1'b0;
      model_cnt = 0;
    end
  endtask

  // Issue tracker: a symbol issued before edge N is due after edge N+1.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld1 <= 1'b0;
      vld2 <= 1'b0;
    end else begin
      vld1 <= issue;
      vld2 <= vld1;
    end
  end

  // Monitor: pop and compare each due character on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (resetn && vld2) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_empty: got no expectation, required one queued");
      end else begin
        e = sb.pop_front();
        chk({e.nm, "_tmds0"}, int'(bus0.tmds), int'(e.t0));
        chk({e.nm, "_tmds1"}, int'(bus1.tmds), int'(e.t1));
        chk({e.nm, "_disp"},  int'(bus0.disparity), e.d);
        if (e.dec) begin
          chk({e.nm, "_decode"}, int'(decode(bus0.tmds)), int'(e.din));
          chk({e.nm, "_bound"}, int'(bus0.disparity > 6'sd10 || bus0.disparity < -6'sd10), 0);
        end
      end
    end
  end

  initial begin
    logic [9:0] t;
    int c;
    logic [7:0] d;
    drive(2'd0, 8'h00, 2'b00, 4'h0);
    repeat (3) @(negedge clk);
    chk("rst_tmds0", int'(bus0.tmds), int'(10'b1101010100));
    chk("rst_tmds1", int'(bus1.tmds), int'(10'b1101010100));
    chk("rst_disp",  int'(bus0.disparity), 0);
    resetn = 1'b1;
    idle(3);
    chk("post_rst_tmds", int'(bus0.tmds), int'(10'b1101010100));
    chk("post_rst_disp", int'(bus0.disparity), 0);

    // Control sweep; din and terc4 hold junk that must be ignored.
    for (int i = 0; i < 4; i++) begin
      c = i;
      send(2'd0, 8'hA5, c[1:0], 4'h7, ctrl_tab[i], ctrl_tab[i], 0, 1'b0, "ctrl");
    end

    // Video zeros after control: A, B, C cases in turn.
    idle(2);
    send(2'd1, 8'h00, 2'b11, 4'hF, 10'b0100000000, 10'b0100000000, -8, 1'b1, "v00a");
    send(2'd1, 8'h00, 2'b11, 4'hF, 10'b1111111111, 10'b1111111111,  2, 1'b1, "v00b");
    send(2'd1, 8'h00, 2'b11, 4'hF, 10'b0100000000, 10'b0100000000, -6, 1'b1, "v00c");

    // 0xFF after control, then control clears disparity.
    send(2'd0, 8'h00, 2'b00, 4'h0, 10'b1101010100, 10'b1101010100, 0, 1'b0, "ctrl_gap");
    send(2'd1, 8'hFF, 2'b00, 4'h0, 10'b1000000000, 10'b1000000000, -8, 1'b1, "vff");
    send(2'd0, 8'hFF, 2'b00, 4'h0, 10'b1101010100, 10'b1101010100, 0, 1'b0, "ctrl_clr");

    // Guard band per lane, then all TERC4 codes.
    send(2'd2, 8'h3C, 2'b01, 4'h2, 10'b1011001100, 10'b0100110011, 0, 1'b0, "guard");
    for (int i = 0; i < 16; i++) begin
      c = i;
      send(2'd3, 8'hC3, 2'b10, c[3:0], terc4_tab[i], terc4_tab[i], 0, 1'b0, "terc4");
    end

    // Video straight after a guard band starts from zero disparity.
    send(2'd2, 8'h00, 2'b00, 4'h0, 10'b1011001100, 10'b0100110011, 0, 1'b0, "guard2");
    send(2'd1, 8'h00, 2'b00, 4'h0, 10'b0100000000, 10'b0100000000, -8, 1'b1, "v_after_guard");

    // Random video stream against the reference model.
    idle(2);
    for (int i = 0; i < 2000; i++) begin
      d = 8'($urandom_range(0, 255));
      model(d, model_cnt, t, c);
      send(2'd1, d, 2'b00, 4'h0, t, t, c, 1'b1, "rand");
      model_cnt = c;
    end

    // Reset mid-video: output returns to control 00 without a clock edge.
    @(negedge clk);
    issue = 1'b0;
    drive(2'd1, 8'h00, 2'b00, 4'h0);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_tmds", int'(bus0.tmds), int'(10'b1101010100));
    chk("async_rst_disp", int'(bus0.disparity), 0);
    sb.delete();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_discard_tmds", int'(bus0.tmds), int'(10'b1101010100));
    chk("rst_discard_disp", int'(bus0.disparity), 0);
    idle(2);
    send(2'd1, 8'hFF, 2'b00, 4'h0, 10'b1000000000, 10'b1000000000, -8, 1'b1, "vff_after_rst");
    idle(1);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
